// File: rtl/pcie_8b10b_pkg.sv
// ---------------------------------------------------------------------------
// pcie_8b10b_pkg
//
// Shared definitions for the PCIe Gen1/Gen2 8b/10b transmit encoder.
// Holds the 5b/6b and 3b/4b code tables, the list of legal control bytes,
// the 10-bit symbol type and a couple of frequently used byte constants.
//
// Code bit order is {a,b,c,d,e,i} for the 6-bit sub-block and {f,g,h,j}
// for the 4-bit sub-block, with the first transmitted bit as the MSB.
// Table rows are indexed by EDCBA (5b) or HGF (3b) of the byte.
// ---------------------------------------------------------------------------
package pcie_8b10b_pkg;

   typedef logic [9:0] sym10_t;

   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] D21_5 = 8'hB5;

   // 5b/6b data codes used when the running disparity is negative
   localparam logic [5:0] ENC6_RDN [0:31] = '{
      6'b100111, 6'b011101, 6'b101101, 6'b110001,
      6'b110101, 6'b101001, 6'b011001, 6'b111000,
      6'b111001, 6'b100101, 6'b010101, 6'b110100,
      6'b001101, 6'b101100, 6'b011100, 6'b010111,
      6'b011011, 6'b100011, 6'b010011, 6'b110010,
      6'b001011, 6'b101010, 6'b011010, 6'b111010,
      6'b110011, 6'b100110, 6'b010110, 6'b110110,
      6'b001110, 6'b101110, 6'b011110, 6'b101011
   };

   // 5b/6b data codes used when the running disparity is positive
   localparam logic [5:0] ENC6_RDP [0:31] = '{
      6'b011000, 6'b100010, 6'b010010, 6'b110001,
      6'b001010, 6'b101001, 6'b011001, 6'b000111,
      6'b000110, 6'b100101, 6'b010101, 6'b110100,
      6'b001101, 6'b101100, 6'b011100, 6'b101000,
      6'b100100, 6'b100011, 6'b010011, 6'b110010,
      6'b001011, 6'b101010, 6'b011010, 6'b000101,
      6'b001100, 6'b100110, 6'b010110, 6'b001001,
      6'b001110, 6'b010001, 6'b100001, 6'b010100
   };

   // K28 is the only control code with its own 6-bit pattern (the comma)
   localparam logic [5:0] K28_6B_RDN = 6'b001111;
   localparam logic [5:0] K28_6B_RDP = 6'b110000;

   // 3b/4b data codes; row 7 holds the primary D.x.P7 form
   localparam logic [3:0] ENC4_D_RDN [0:7] = '{
      4'b1011, 4'b1001, 4'b0101, 4'b1100,
      4'b1101, 4'b1010, 4'b0110, 4'b1110
   };
   localparam logic [3:0] ENC4_D_RDP [0:7] = '{
      4'b0100, 4'b1001, 4'b0101, 4'b0011,
      4'b0010, 4'b1010, 4'b0110, 4'b0001
   };

   // Alternate D.x.A7 form, avoids a run of five equal bits across i/f
   localparam logic [3:0] ENC4_A7_RDN = 4'b0111;
   localparam logic [3:0] ENC4_A7_RDP = 4'b1000;

   // 3b/4b control codes
   localparam logic [3:0] ENC4_K_RDN [0:7] = '{
      4'b1011, 4'b0110, 4'b1010, 4'b1100,
      4'b1101, 4'b0101, 4'b1001, 4'b0111
   };
   localparam logic [3:0] ENC4_K_RDP [0:7] = '{
      4'b0100, 4'b1001, 4'b0101, 4'b0011,
      4'b0010, 4'b1010, 4'b0110, 4'b1000
   };

   // Every byte that may be sent as a control symbol
   localparam int NUM_LEGAL_K = 12;
   localparam logic [7:0] LEGAL_K [0:NUM_LEGAL_K-1] = '{
      8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
      8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE
   };

   function automatic logic is_legal_k(input logic [7:0] b);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NUM_LEGAL_K; i++) begin
         if (b == LEGAL_K[i]) hit = 1'b1;
      end
      return hit;
   endfunction

   // A 6-bit sub-block is balanced when it has exactly three ones
   function automatic logic unbalanced6(input logic [5:0] c);
      int ones;
      ones = 0;
      for (int i = 0; i < 6; i++) ones = ones + int'(c[i]);
      return (ones != 3);
   endfunction

   // A 4-bit sub-block is balanced when it has exactly two ones
   function automatic logic unbalanced4(input logic [3:0] c);
      int ones;
      ones = 0;
      for (int i = 0; i < 4; i++) ones = ones + int'(c[i]);
      return (ones != 2);
   endfunction

endpackage

// File: rtl/encoder_8b10b_lane.sv
// ---------------------------------------------------------------------------
// encoder_8b10b_lane
//
// Purely combinational single-byte 8b/10b encoder. Lanes are chained by the
// parent so that rd_out of one lane feeds rd_in of the next.
//
// Ports:
//   data    8-bit byte, HGF EDCBA
//   is_k    encode as a control symbol
//   rd_in   running disparity before this symbol (1 = RD+)
//   sym     10-bit symbol {a,b,c,d,e,i,f,g,h,j}, a is the MSB
//   rd_out  running disparity after this symbol
//   k_err   control byte was not a legal K code
//
// Build option ENCODER_8B10B_KCHECK_EN: when defined, illegal control bytes
// raise k_err and are sent as the data code of the same byte. When not
// defined, k_err is 0 and the control tables are used unchecked.
// ---------------------------------------------------------------------------
module encoder_8b10b_lane
   import pcie_8b10b_pkg::*;
(
   input  logic [7:0] data,
   input  logic       is_k,
   input  logic       rd_in,
   output sym10_t     sym,
   output logic       rd_out,
   output logic       k_err
);

   logic [4:0] x;
   logic [2:0] y;
   logic       use_k;
   logic [5:0] six;
   logic [3:0] four;
   logic       rd_mid;
   logic       use_a7;

   assign x = data[4:0];
   assign y = data[7:5];

`ifdef ENCODER_8B10B_KCHECK_EN
   assign k_err = is_k && !is_legal_k(data);
   assign use_k = is_k && !k_err;
`else
   assign k_err = 1'b0;
   assign use_k = is_k;
`endif

   // 5b/6b stage: K23/K27/K29/K30 share the data 6-bit codes, only K28 differs.
   // An unbalanced sub-block flips the disparity seen by the 3b/4b stage.
   always_comb begin
      six = rd_in ? ENC6_RDP[x] : ENC6_RDN[x];
      if (use_k && (x == 5'd28)) begin
         six = rd_in ? K28_6B_RDP : K28_6B_RDN;
      end
      rd_mid = unbalanced6(six) ? !rd_in : rd_in;
   end

   // 3b/4b stage runs off the disparity left by the 6-bit sub-block. The A7
   // alternate is only needed where the P7 form would extend the run of equal
   // bits that the 6-bit code ends with.
   always_comb begin
      use_a7 = (!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
               ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
      if (use_k) begin
         four = rd_mid ? ENC4_K_RDP[y] : ENC4_K_RDN[y];
      end else if ((y == 3'd7) && use_a7) begin
         four = rd_mid ? ENC4_A7_RDP : ENC4_A7_RDN;
      end else begin
         four = rd_mid ? ENC4_D_RDP[y] : ENC4_D_RDN[y];
      end
      rd_out = unbalanced4(four) ? !rd_mid : rd_mid;
   end

   assign sym = {six, four};

endmodule

// File: rtl/encoder_8b10b_multi.sv
// ---------------------------------------------------------------------------
// encoder_8b10b_multi
//
// Multi-symbol 8b/10b encoder for the PCIe Gen1/Gen2 transmit path. Encodes
// NUM_SYM bytes per beat with running disparity chained lane 0 -> lane N-1,
// and carried across beats in rd_q. One registered output stage behind a
// valid/ready handshake (no skid buffer).
//
// Parameters:
//   NUM_SYM      symbols per beat, 1, 2 or 4
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   in_valid_i   input beat valid
//   in_ready_o   a beat can be taken this cycle
//   data_i       bytes, lane n = [8n+7:8n], lane 0 goes out first
//   is_k_i       per-lane control flag
//   disp_set_i   load RD from disp_val_i before encoding this beat
//   disp_val_i   RD to load, 1 = RD+
//   out_valid_o  output beat valid
//   out_ready_i  downstream takes the output beat
//   symbol_o     symbols, lane n = [10n+9:10n]
//   rd_o         RD after the last lane of the output beat
//   k_err_o      per-lane illegal control byte flag
//
// Build option ENCODER_8B10B_KCHECK_EN enables illegal-K detection in the
// lanes; without it k_err_o stays 0.
// ---------------------------------------------------------------------------
module encoder_8b10b_multi
   import pcie_8b10b_pkg::*;
#(
   parameter int NUM_SYM = 2
)
(
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [8*NUM_SYM-1:0]    data_i,
   input  logic [NUM_SYM-1:0]      is_k_i,
   input  logic                    disp_set_i,
   input  logic                    disp_val_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [10*NUM_SYM-1:0]   symbol_o,
   output logic                    rd_o,
   output logic [NUM_SYM-1:0]      k_err_o
);

   logic                  accept;
   logic                  rd_q;
   logic                  out_valid_q;
   logic [10*NUM_SYM-1:0] sym_q;
   logic [NUM_SYM-1:0]    kerr_q;
   logic [10*NUM_SYM-1:0] sym_next;
   logic [NUM_SYM-1:0]    kerr_next;
   logic                  rd_chain [0:NUM_SYM];

   // The register frees up either when it is empty or when it drains this
   // cycle, so out_ready_i reaches in_ready_o combinationally.
   assign in_ready_o = !out_valid_q || out_ready_i;
   assign accept     = in_valid_i && in_ready_o;

   // Lane 0 starts either from the loaded value or from the last beat's RD
   assign rd_chain[0] = disp_set_i ? disp_val_i : rd_q;

   for (genvar n = 0; n < NUM_SYM; n++) begin : g_lane
      encoder_8b10b_lane u_lane (
         .data   (data_i[8*n +: 8]),
         .is_k   (is_k_i[n]),
         .rd_in  (rd_chain[n]),
         .sym    (sym_next[10*n +: 10]),
         .rd_out (rd_chain[n+1]),
         .k_err  (kerr_next[n])
      );
   end

   // Output stage and carried disparity. Everything only moves on accept, so
   // a stalled beat and its RD stay put; a drain without a new beat just
   // drops valid. rd_q doubles as the registered rd_o since both update
   // together.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_valid_q <= 1'b0;
         sym_q       <= '0;
         kerr_q      <= '0;
         rd_q        <= 1'b0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         sym_q       <= sym_next;
         kerr_q      <= kerr_next;
         rd_q        <= rd_chain[NUM_SYM];
      end else if (out_ready_i) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid_o = out_valid_q;
   assign symbol_o    = sym_q;
   assign k_err_o     = kerr_q;
   assign rd_o        = rd_q;

endmodule

// File: tb/tb_encoder_8b10b_multi.sv
// ---------------------------------------------------------------------------
// tb_encoder_8b10b_multi
//
// Directed bench for encoder_8b10b_multi with NUM_SYM = 2: reset values,
// hand-encoded symbols at both disparities, disparity load, backpressure,
// reset during a stall, optional illegal-K handling, and a randomised stream
// whose symbols are checked for disparity and run-length rules.
// ---------------------------------------------------------------------------
module tb_encoder_8b10b_multi;
   import pcie_8b10b_pkg::*;

   localparam int NUM_SYM = 2;

   logic                  clk_i = 1'b0;
   logic                  rst_i;
   logic                  in_valid_i;
   logic                  in_ready_o;
   logic [8*NUM_SYM-1:0]  data_i;
   logic [NUM_SYM-1:0]    is_k_i;
   logic                  disp_set_i;
   logic                  disp_val_i;
   logic                  out_valid_o;
   logic                  out_ready_i;
   logic [10*NUM_SYM-1:0] symbol_o;
   logic                  rd_o;
   logic [NUM_SYM-1:0]    k_err_o;

   int error_count = 0;
   int check_count = 0;

   encoder_8b10b_multi #(.NUM_SYM(NUM_SYM)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .data_i      (data_i),
      .is_k_i      (is_k_i),
      .disp_set_i  (disp_set_i),
      .disp_val_i  (disp_val_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .symbol_o    (symbol_o),
      .rd_o        (rd_o),
      .k_err_o     (k_err_o)
   );

   always #5 clk_i = ~clk_i;

   // Safety net so a wedged run still ends
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_count++;
      if (got !== exp) begin
         error_count++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Present one beat at a negedge, let it be taken at the posedge, and come
   // back at the following negedge with the input idle. Assumes out_ready_i=1.
   task automatic apply_stimulus(input logic [15:0] data, input logic [1:0] isk,
                                 input logic dset, input logic dval);
      data_i     = data;
      is_k_i     = isk;
      disp_set_i = dset;
      disp_val_i = dval;
      in_valid_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      in_valid_i = 1'b0;
      disp_set_i = 1'b0;
   endtask

   task automatic check_beat(input string tag, input logic [19:0] exp_sym,
                             input logic exp_rd, input logic [1:0] exp_kerr);
      check_output({tag, "_valid"}, out_valid_o, 1'b1);
      check_output({tag, "_sym"},   symbol_o,    exp_sym);
      check_output({tag, "_rd"},    rd_o,        exp_rd);
      check_output({tag, "_kerr"},  k_err_o,     exp_kerr);
   endtask

   // Hand-encoded single symbols: byte, control flag, RD in, symbol, RD out
   typedef struct packed {
      logic [7:0] data;
      logic       k;
      logic       rd_in;
      logic [9:0] sym;
      logic       rd_out;
   } vec_t;

   localparam int NUM_VEC = 18;
   vec_t vecs [NUM_VEC] = '{
      '{8'h00, 1'b0, 1'b0, 10'h274, 1'b0},   // D0.0  RD-
      '{8'h00, 1'b0, 1'b1, 10'h18B, 1'b1},   // D0.0  RD+
      '{8'h63, 1'b0, 1'b0, 10'h31C, 1'b0},   // D3.3  RD-
      '{8'h27, 1'b0, 1'b1, 10'h079, 1'b1},   // D7.1  RD+
      '{8'h97, 1'b0, 1'b0, 10'h3A2, 1'b0},   // D23.4 RD-
      '{8'hDF, 1'b0, 1'b1, 10'h146, 1'b0},   // D31.6 RD+
      '{8'hEB, 1'b0, 1'b1, 10'h348, 1'b0},   // D11.7 RD+ A7
      '{8'hF1, 1'b0, 1'b0, 10'h237, 1'b1},   // D17.7 RD- A7
      '{8'hF1, 1'b0, 1'b1, 10'h231, 1'b0},   // D17.7 RD+ P7
      '{8'hEB, 1'b0, 1'b0, 10'h34E, 1'b1},   // D11.7 RD- P7
      '{8'hFC, 1'b1, 1'b0, 10'h0F8, 1'b0},   // K28.7 RD-
      '{8'hF7, 1'b1, 1'b0, 10'h3A8, 1'b0},   // K23.7 RD-
      '{8'h3C, 1'b1, 1'b1, 10'h306, 1'b0},   // K28.1 RD+
      '{8'hB5, 1'b0, 1'b1, 10'h2AA, 1'b1},   // D21.5 RD+
      '{8'h45, 1'b0, 1'b0, 10'h295, 1'b0},   // D5.2  RD-
      '{8'h10, 1'b0, 1'b1, 10'h24B, 1'b1},   // D16.0 RD+
      '{8'hDC, 1'b1, 1'b0, 10'h0F6, 1'b1},   // K28.6 RD-
      '{8'hBC, 1'b1, 1'b0, 10'h0FA, 1'b1}    // K28.5 RD-
   };

   logic [7:0] k_list [11] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                               8'hDC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

   initial begin
      int beats_in;
      int beats_out;
      logic track_rd;
      logic last_bit;
      int run_len;

      rst_i       = 1'b1;
      in_valid_i  = 1'b0;
      data_i      = '0;
      is_k_i      = '0;
      disp_set_i  = 1'b0;
      disp_val_i  = 1'b0;
      out_ready_i = 1'b1;

      // Reset values, both while held and right after release
      repeat (3) @(negedge clk_i);
      check_output("rst_valid", out_valid_o, 1'b0);
      check_output("rst_sym",   symbol_o,    20'h0);
      check_output("rst_rd",    rd_o,        1'b0);
      check_output("rst_kerr",  k_err_o,     2'b00);
      check_output("rst_ready", in_ready_o,  1'b1);
      rst_i = 1'b0;
      @(negedge clk_i);
      check_output("post_rst_valid", out_valid_o, 1'b0);

      // K28.5 pair from reset RD-
      apply_stimulus({K28_5, K28_5}, 2'b11, 1'b0, 1'b0);
      check_beat("k285_pair", {10'h305, 10'h0FA}, 1'b0, 2'b00);
      @(negedge clk_i);
      check_output("drain_valid", out_valid_o, 1'b0);

      // Balanced D21.5 leaves RD- for the D0.0 behind it
      apply_stimulus({8'h00, D21_5}, 2'b00, 1'b0, 1'b0);
      check_beat("d215_d00", {10'h274, 10'h2AA}, 1'b0, 2'b00);
      apply_stimulus(16'h0000, 2'b00, 1'b0, 1'b0);
      check_beat("d00_d00", {10'h274, 10'h274}, 1'b0, 2'b00);

      // Disparity load to RD+, then carry RD+ into the next beat
      apply_stimulus({K28_5, K28_5}, 2'b11, 1'b1, 1'b1);
      check_beat("load_rdp", {10'h0FA, 10'h305}, 1'b1, 2'b00);
      apply_stimulus(16'h0000, 2'b00, 1'b0, 1'b0);
      check_beat("carry_rdp", {10'h18B, 10'h18B}, 1'b1, 2'b00);

      // Single-symbol table; lane 1 carries the balanced D21.5
      for (int i = 0; i < NUM_VEC; i++) begin
         apply_stimulus({D21_5, vecs[i].data}, {1'b0, vecs[i].k}, 1'b1, vecs[i].rd_in);
         check_beat($sformatf("vec%0d", i), {10'h2AA, vecs[i].sym}, vecs[i].rd_out, 2'b00);
      end

      // Control flag on a byte that is not a legal K code
      apply_stimulus({D21_5, 8'h00}, 2'b01, 1'b1, 1'b0);
`ifdef ENCODER_8B10B_KCHECK_EN
      check_beat("illegal_k", {10'h2AA, 10'h274}, 1'b0, 2'b01);
`else
      check_output("illegal_k_kerr", k_err_o, 2'b00);
`endif
      @(negedge clk_i);

      // Backpressure: beat A stalls for three cycles while B waits
      out_ready_i = 1'b0;
      data_i      = {D21_5, K28_5};
      is_k_i      = 2'b01;
      disp_set_i  = 1'b1;
      disp_val_i  = 1'b0;
      in_valid_i  = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      data_i     = 16'h0000;
      is_k_i     = 2'b00;
      disp_set_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_output($sformatf("stall%0d_ready", i), in_ready_o, 1'b0);
         check_beat($sformatf("stall%0d", i), {10'h2AA, 10'h0FA}, 1'b1, 2'b00);
         @(negedge clk_i);
      end
      out_ready_i = 1'b1;
      #1;
      check_output("release_ready", in_ready_o, 1'b1);
      @(posedge clk_i);
      @(negedge clk_i);
      in_valid_i = 1'b0;
      check_beat("after_stall", {10'h18B, 10'h18B}, 1'b1, 2'b00);
      @(negedge clk_i);
      check_output("no_dup_valid", out_valid_o, 1'b0);

      // Reset arriving while a beat is stalled
      out_ready_i = 1'b0;
      data_i      = {D21_5, K28_5};
      is_k_i      = 2'b01;
      disp_set_i  = 1'b1;
      disp_val_i  = 1'b0;
      in_valid_i  = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      in_valid_i = 1'b0;
      disp_set_i = 1'b0;
      check_beat("pre_rst_stall", {10'h2AA, 10'h0FA}, 1'b1, 2'b00);
      #2 rst_i = 1'b1;
      #1;
      check_output("midrst_valid", out_valid_o, 1'b0);
      check_output("midrst_sym",   symbol_o,    20'h0);
      check_output("midrst_rd",    rd_o,        1'b0);
      check_output("midrst_ready", in_ready_o,  1'b1);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);

      // Random stream under random backpressure, checked for disparity
      // bookkeeping, sub-block balance limits and maximum run length
      beats_in  = 0;
      beats_out = 0;
      track_rd  = 1'b0;
      last_bit  = 1'b0;
      run_len   = 0;
      for (int cyc = 0; cyc < 8000 && beats_out < 1000; cyc++) begin
         logic        v;
         logic        r;
         logic [19:0] s;
         logic        rdo;
         logic [1:0]  ke;
         in_valid_i  = ($urandom_range(0, 3) != 0);
         out_ready_i = ($urandom_range(0, 3) != 0);
         for (int l = 0; l < NUM_SYM; l++) begin
            if ($urandom_range(0, 7) == 0) begin
               data_i[8*l +: 8] = k_list[$urandom_range(0, 10)];
               is_k_i[l]        = 1'b1;
            end else begin
               data_i[8*l +: 8] = 8'($urandom_range(0, 255));
               is_k_i[l]        = 1'b0;
            end
         end
         #1;
         v   = out_valid_o;
         r   = out_ready_i;
         s   = symbol_o;
         rdo = rd_o;
         ke  = k_err_o;
         if (in_valid_i && in_ready_o) beats_in++;
         @(posedge clk_i);
         if (v && r) begin
            int max_run;
            max_run = 0;
            for (int l = 0; l < NUM_SYM; l++) begin
               logic [9:0] sym;
               int ones;
               int ones6;
               int ones4;
               logic ok;
               sym   = s[10*l +: 10];
               ones  = $countones(sym);
               ones6 = $countones(sym[9:4]);
               ones4 = $countones(sym[3:0]);
               ok = track_rd ? ((ones == 5) || (ones == 4)) : ((ones == 5) || (ones == 6));
               check_output("rs_disp", ok, 1'b1);
               if (ones != 5) track_rd = !track_rd;
               check_output("rs_subblk", (ones6 >= 2) && (ones6 <= 4) && (ones4 >= 1) && (ones4 <= 3), 1'b1);
               for (int b = 9; b >= 0; b--) begin
                  if ((run_len == 0) || (sym[b] != last_bit)) begin
                     last_bit = sym[b];
                     run_len  = 1;
                  end else begin
                     run_len++;
                  end
                  if (run_len > max_run) max_run = run_len;
               end
            end
            check_output("rs_runlen", max_run <= 5, 1'b1);
            check_output("rs_rd",     rdo,          track_rd);
            check_output("rs_kerr",   ke,           2'b00);
            beats_out++;
         end
         @(negedge clk_i);
      end
      in_valid_i = 1'b0;
      check_output("rs_beats", beats_out, 1000);
      check_output("rs_no_loss", beats_in, beats_out + int'(out_valid_o));

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule
